// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the Execute stage and the
// multi-cycle multiply/divide unit.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_hilo;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] mt_data;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_zero;

    // Pipeline side: issues requests, observes HI/LO and status
    modport master (
        output start, op, src_a, src_b, rd_hilo, mt_hi, mt_lo, mt_data, flush,
        input  hi, lo, busy, stall, done, div_zero
    );

    // Unit side: consumes requests, owns HI/LO and status
    modport slave (
        input  start, op, src_a, src_b, rd_hilo, mt_hi, mt_lo, mt_data, flush,
        output hi, lo, busy, stall, done, div_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO register pair.
// Signed operands are reduced to magnitudes on issue, 32 radix-2 steps run
// in CALC (shift-add multiply or restoring divide), and FIX restores signs
// before HI/LO are written and done pulses.
module muldiv_sequencer (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t              r_state;
    logic [5:0]          r_cnt;
    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [DATA_W-1:0]   r_opnd;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_q;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;
    logic                r_dz;

    logic                w_busy;
    logic                w_sgn_op;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W:0]     w_msum;
    logic [DATA_W:0]     w_dshift;
    logic [DATA_W-1:0]   w_ddiff;
    logic                w_dge;
    logic                w_b_zero;
    logic [2*DATA_W-1:0] w_mres;
    logic [DATA_W-1:0]   w_qres;
    logic [DATA_W-1:0]   w_rres;

    function automatic logic signed [DATA_W-1:0] f_neg32(input logic signed [DATA_W-1:0] v);
        return -v;
    endfunction

    function automatic logic signed [2*DATA_W-1:0] f_neg64(input logic signed [2*DATA_W-1:0] v);
        return -v;
    endfunction

    function automatic logic [DATA_W-1:0] f_abs32(input logic signed [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? f_neg32(v) : v;
    endfunction

    // Operand conditioning on issue and one iteration of the datapath
    always_comb begin
        w_sgn_op = ~bus.op[0];
        w_a_mag  = f_abs32(bus.src_a, w_sgn_op);
        w_b_mag  = f_abs32(bus.src_b, w_sgn_op);
        // Multiply: add multiplicand into the upper half when the LSB of the multiplier is set
        w_msum   = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_opnd} : '0);
        // Divide: shift next dividend bit into the partial remainder and trial-subtract
        w_dshift = {r_rem, r_q[DATA_W-1]};
        w_dge    = (w_dshift >= {1'b0, r_opnd});
        w_ddiff  = w_dshift[DATA_W-1:0] - r_opnd;
        // Sign correction; a zero divisor leaves an all-ones quotient, and the
        // remainder sign fix turns |a| back into the original dividend
        w_b_zero = (r_opnd == '0);
        w_mres   = r_neg_q ? f_neg64({r_rem, r_q}) : {r_rem, r_q};
        w_qres   = w_b_zero ? '1 : (r_neg_q ? f_neg32(r_q) : r_q);
        w_rres   = r_neg_r ? f_neg32(r_rem) : r_rem;
    end

    // Sequencer FSM with HI/LO ownership and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_opnd   <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.mt_hi) r_hi <= bus.mt_data;
                    if (bus.mt_lo) r_lo <= bus.mt_data;
                    if (bus.start && !bus.flush) begin
                        r_is_div <= bus.op[1];
                        r_neg_q  <= w_sgn_op & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
                        r_neg_r  <= w_sgn_op & bus.src_a[DATA_W-1];
                        r_opnd   <= bus.op[1] ? w_b_mag : w_a_mag;
                        r_q      <= bus.op[1] ? w_a_mag : w_b_mag;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        r_state <= IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_rem <= w_dge ? w_ddiff : w_dshift[DATA_W-1:0];
                            r_q   <= {r_q[DATA_W-2:0], w_dge};
                        end else begin
                            {r_rem, r_q} <= {w_msum, r_q[DATA_W-1:1]};
                        end
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    if (!bus.flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rres;
                            r_lo <= w_qres;
                        end else begin
                            {r_hi, r_lo} <= w_mres;
                        end
                        r_done <= 1'b1;
                        r_dz   <= r_is_div & w_b_zero;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_busy       = (r_state != IDLE);
    assign bus.busy     = w_busy;
    assign bus.stall    = w_busy & (bus.start | bus.rd_hilo | bus.mt_hi | bus.mt_lo);
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.done     = r_done;
    assign bus.div_zero = r_dz;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain
// arithmetic model of MIPS-style HI/LO results.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {div_zero, hi, lo}
    function automatic logic [64:0] f_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic        [63:0] up;
        logic signed [31:0] sa, sb, sq, sr;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return {1'b0, sp};
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                return {1'b0, up};
            end
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, 32'h80000000};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr, sq};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corner [5];
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000;
        corner[4] = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Issue one operation now, follow it to its done cycle and compare.
    // Returns positioned in the done cycle so a caller may issue back-to-back.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
        logic [64:0] m;
        int          nbusy;
        bit          bad_out, bad_stall, got_done;
        m         = f_model(op, a, b);
        nbusy     = 0;
        bad_out   = 1'b0;
        bad_stall = 1'b0;
        got_done  = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        step();
        bus.start = 1'b0;
        check("done_low_after_issue", bus.done, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy) nbusy++;
            if (bus.div_zero || bus.hi !== exp_hi || bus.lo !== exp_lo) bad_out = 1'b1;
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.op    = 2'($urandom);
                bus.src_a = $urandom;
                bus.src_b = $urandom;
                #1;
                if (bus.stall !== bus.start) bad_stall = 1'b1;
            end
            step();
        end
        bus.start = 1'b0;
        check("done_seen", got_done, 1'b1);
        check("busy_cycles", nbusy, 33);
        check("hold_while_busy", bad_out, 1'b0);
        if (noise) check("stall_on_reissue", bad_stall, 1'b0);
        exp_hi = m[63:32];
        exp_lo = m[31:0];
        check("hi", bus.hi, exp_hi);
        check("lo", bus.lo, exp_lo);
        check("div_zero", bus.div_zero, m[64]);
        check("busy_in_done", bus.busy, 1'b0);
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        bit          got;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.rd_hilo = 1'b0;
        bus.mt_hi   = 1'b0;
        bus.mt_lo   = 1'b0;
        bus.mt_data = '0;
        bus.flush   = 1'b0;
        exp_hi      = '0;
        exp_lo      = '0;

        repeat (2) step();
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_div_zero", bus.div_zero, 1'b0);
        rst = 1'b1;
        step();

        // Directed corner operations with hand-computed results
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        check("multu_max_hi", bus.hi, 32'hFFFFFFFE);
        check("multu_max_lo", bus.lo, 32'h00000001);
        step();
        check("done_one_cycle", bus.done, 1'b0);
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0);
        check("mult_neg_hi", bus.hi, 32'hFFFFFFFF);
        check("mult_neg_lo", bus.lo, 32'hFFFFFFF1);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_neg_lo", bus.lo, 32'hFFFFFFFD);
        check("div_neg_hi", bus.hi, 32'hFFFFFFFF);
        run_op(2'b11, 32'h64, 32'd0, 1'b0);
        check("divu_zero_lo", bus.lo, 32'hFFFFFFFF);
        check("divu_zero_hi", bus.hi, 32'h64);
        check("divu_zero_flag", bus.div_zero, 1'b1);
        step();
        check("div_zero_one_cycle", bus.div_zero, 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf_lo", bus.lo, 32'h80000000);
        check("div_ovf_hi", bus.hi, 32'h0);
        step();

        // Randomized operations, reissue noise while busy, occasional back-to-back
        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom);
            ra  = pick();
            rb  = pick();
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                step();
                check("done_pulse_end", bus.done, 1'b0);
            end
        end
        step();

        // Stall is only raised while busy
        bus.rd_hilo = 1'b1;
        #1;
        check("stall_idle", bus.stall, 1'b0);
        bus.rd_hilo = 1'b0;

        // MFHI stall mid-multiply, then flush cancels it
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = 32'd7;
        bus.src_b = 32'd9;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        bus.rd_hilo = 1'b1;
        #1;
        check("stall_rd_hilo", bus.stall, 1'b1);
        step();
        bus.rd_hilo = 1'b0;
        #1;
        check("stall_released", bus.stall, 1'b0);
        repeat (4) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 1'b0);
        check("flush_hi", bus.hi, exp_hi);
        check("flush_lo", bus.lo, exp_lo);
        wait_done(got);
        check("flush_no_done", got, 1'b0);

        // Flush in IDLE suppresses a start
        bus.start = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_idle_start", bus.busy, 1'b0);

        // MTHI in IDLE
        bus.mt_hi   = 1'b1;
        bus.mt_data = 32'h1234;
        step();
        bus.mt_hi = 1'b0;
        check("mthi", bus.hi, 32'h1234);

        // MTLO together with start: write lands, result overwrites it later
        bus.mt_lo   = 1'b1;
        bus.mt_data = 32'hABCD;
        bus.start   = 1'b1;
        bus.op      = 2'b01;
        bus.src_a   = 32'd2;
        bus.src_b   = 32'd3;
        step();
        bus.mt_lo = 1'b0;
        bus.start = 1'b0;
        check("mtlo_with_start", bus.lo, 32'hABCD);
        wait_done(got);
        check("mtlo_start_done", got, 1'b1);
        check("mtlo_start_lo", bus.lo, 32'd6);
        check("mtlo_start_hi", bus.hi, 32'd0);
        step();

        // MTLO during busy stalls and is dropped
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        step();
        bus.start = 1'b0;
        step();
        bus.mt_lo   = 1'b1;
        bus.mt_data = 32'h5555;
        #1;
        check("stall_mtlo", bus.stall, 1'b1);
        step();
        bus.mt_lo = 1'b0;
        check("mtlo_busy_ignored", bus.lo, 32'd6);
        wait_done(got);
        check("divu_done", got, 1'b1);
        check("divu_lo", bus.lo, 32'd14);
        check("divu_hi", bus.hi, 32'd2);
        step();

        // Asynchronous reset in the middle of a DIVU
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.src_a = $urandom;
        bus.src_b = 32'd3;
        step();
        bus.start = 1'b0;
        repeat (19) step();
        bus.rd_hilo = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_stall", bus.stall, 1'b0);
        check("arst_done", bus.done, 1'b0);
        check("arst_div_zero", bus.div_zero, 1'b0);
        bus.rd_hilo = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        wait_done(got);
        check("arst_no_done", got, 1'b0);
        check("arst_hi_after", bus.hi, 32'd0);
        check("arst_lo_after", bus.lo, 32'd0);
        exp_hi = '0;
        exp_lo = '0;

        run_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 1'b1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have a single clock, clk; reset is asynchronous and active-low, port rst (design asserts reset when rst=0).
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- start  in  1  Execute stage issues mul/div this cycle
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- src_a  in  32  multiplicand / dividend (forwarded operand)
- src_b  in  32  multiplier / divisor
- rd_hilo  in  1  MFHI/MFLO in Execute this cycle
- mt_hi  in  1  MTHI write request
- mt_lo  in  1  MTLO write request
- mt_data  in  32  MTHI/MTLO data
- flush  in  1  cancel the in-flight operation
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight
- stall  out  1  pipeline stall request
- done  out  1  one-cycle pulse: new HI/LO valid
- div_zero  out  1  accompanies done when divisor was 0

Function
REQ-003 SHALL implement FSM states IDLE, CALC, FIX.
REQ-004 IDLE: start=1 and flush=0 at edge E -> latch |src_a|, |src_b| (signed ops) or raw values (unsigned ops), result signs, op; counter<=0; go CALC.
REQ-005 CALC: one radix-2 iteration per cycle (shift-add multiply; restoring divide), counter +1 per cycle; after 32 iterations go FIX.
REQ-006 FIX: one cycle applying sign correction; at the edge leaving FIX, write HI/LO and go IDLE.
REQ-007 Latency: start sampled at edge 0 -> busy=1 cycles 1..33, HI/LO updated at edge 34, done=1 during cycle 34 only.
REQ-008 busy SHALL equal (state != IDLE), registered-state derived, no combinational dependence on inputs.
REQ-009 stall SHALL be combinational: busy & (start | rd_hilo | mt_hi | mt_lo); stall=0 whenever busy=0.
REQ-010 start, mt_hi, mt_lo while busy=1 SHALL be ignored (the pipeline is stalled and reissues them).
REQ-011 Multiply: {HI,LO} = 64-bit product; signed result = two's-complement negation of magnitude when sign(a)^sign(b).
REQ-012 Divide: LO = quotient, HI = remainder; quotient sign = sign(a)^sign(b), remainder sign = sign(a) (truncating division).
REQ-013 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000 (wrap, no exception).
REQ-014 Divisor 0 (DIV or DIVU): LO=0xFFFFFFFF, HI=src_a as latched, div_zero=1 with done; div_zero=0 in all other cycles.
REQ-015 flush=1 while busy: next edge state<=IDLE, HI/LO unchanged, no done pulse; flush in IDLE with start: start ignored.
REQ-016 In IDLE, mt_hi/mt_lo write mt_data to HI/LO at the next edge; if issued together with start, the mt write applies and the later result overwrites it.
REQ-017 done and a new start in the same cycle (state IDLE) SHALL be accepted; back-to-back operations have a 34-cycle issue interval.
REQ-018 hi/lo outputs SHALL be driven directly from registers.

Reset
REQ-019 rst=0 SHALL immediately force state=IDLE, counter=0, HI=LO=0, busy=0, done=0, div_zero=0, latched operands 0, independent of clk.
REQ-020 Reset mid-operation SHALL discard the operation; no done after rst deasserts.

Verification
REQ-021 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> edge 34: HI=0xFFFFFFFE, LO=0x00000001, done pulse cycle 34 only, busy cycles 1..33.
REQ-022 MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-023 DIVU 0x64 / 0 -> LO=0xFFFFFFFF, HI=0x00000064, div_zero=1 with done; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-024 Start MULT, assert rd_hilo at cycle 5 -> stall=1 cycle 5; flush at cycle 10 -> busy=0 cycle 11, HI/LO unchanged, no done.
REQ-025 MTHI 0x1234 in IDLE -> HI=0x1234 next edge; MTLO during busy -> stall=1, LO unchanged.
REQ-026 rst=0 asynchronously at cycle 20 of a DIVU -> all outputs zero immediately; after release, no done, HI=LO=0.
